display_bcd_driver: RTL

Converts a 20-bit unsigned binary value into six decimal digits and drives the DE0-CV seven-segment outputs HEX0..HEX5 directly. Sits directly upstream of the board top level: the top level instantiates it and wires its hex outputs to the board pins. It uses a sequential double-dabble converter with a valid/ready input handshake, and holds its outputs registered between updates.

---
 rtl/display_bcd_driver.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/display_bcd_driver.sv
// Sequential double-dabble converter from a 20-bit binary value to six seven-segment digits.
// Optional build macro: DISPLAY_LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero one.
module display_bcd_driver (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] in_value,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_update,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [1:0]  dbg_state
);

  // Handshake: a value transfers on a rising edge where in_valid and in_ready are both high;
  // in_ready is high only in IDLE, and the source must hold in_valid/in_value until then.

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_LOAD    = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  state_t      state_q, state_d;
  logic [19:0] bin_q, bin_d;
  logic [23:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        ready_q, ready_d;
  logic        upd_q, upd_d;
  logic [41:0] hex_q, hex_d;
  logic [23:0] bcd_adj;
  logic [41:0] hex_load;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 6; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Scan from the top digit down so blanking stops at the first nonzero digit.
  always_comb begin
    logic seen_nonzero;
    logic [6:0] code;
    seen_nonzero = 1'b0;
    code = SEG_BLANK;
    hex_load = {6{SEG_BLANK}};
    for (int i = 5; i >= 0; i--) begin
      code = seg7(bcd_q[4*i +: 4]);
      if (bcd_q[4*i +: 4] != 4'd0) seen_nonzero = 1'b1;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
      if (!seen_nonzero && i != 0) code = SEG_BLANK;
`endif
      if (ovf_q) code = SEG_DASH;
      hex_load[7*i +: 7] = code;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    ready_d = ready_q;
    upd_d   = 1'b0;
    hex_d   = hex_q;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (in_valid && ready_q) begin
          bin_d   = in_value;
          bcd_d   = 24'd0;
          cnt_d   = 5'd0;
          ovf_d   = (in_value > 20'd999999);
          ready_d = 1'b0;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        bcd_d = {bcd_adj[22:0], bin_q[19]};
        bin_d = {bin_q[18:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd19) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        hex_d   = hex_load;
        upd_d   = 1'b1;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bin_q   <= 20'd0;
      bcd_q   <= 24'd0;
      cnt_q   <= 5'd0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      upd_q   <= 1'b0;
      hex_q   <= {6{SEG_BLANK}};
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      upd_q   <= upd_d;
      hex_q   <= hex_d;
    end
  end

  assign in_ready   = ready_q;
  assign out_update = upd_q;
  assign hex0       = hex_q[6:0];
  assign hex1       = hex_q[13:7];
  assign hex2       = hex_q[20:14];
  assign hex3       = hex_q[27:21];
  assign hex4       = hex_q[34:28];
  assign hex5       = hex_q[41:35];
  assign dbg_state  = state_q;

endmodule
